// File: rtl/simd_batch_scheduler.sv
// simd_batch_scheduler: issues N SIMD batches (start/done handshake) with address stepping and a hang timeout
// Ports: clk/rst (async active-high); cfg_start, cfg_base_addr, cfg_num_batches, abort in;
//        simd_start out / simd_done in to the SIMD control FSM;
//        batch_addr, batch_idx, batches_done, busy, done, error out (all decoded from registers).
module simd_batch_scheduler #(
  parameter int ADDR_W  = 16,
  parameter int LANES   = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [CNT_W-1:0]  cfg_num_batches,
  input  logic              abort,
  output logic              simd_start,
  input  logic              simd_done,
  output logic [ADDR_W-1:0] batch_addr,
  output logic [CNT_W-1:0]  batch_idx,
  output logic [CNT_W-1:0]  batches_done,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, FINISH, ERR} state_t;
  state_t          state;
  logic [CNT_W-1:0] num;
  logic [TW-1:0]    timer;
  assign simd_start = state == ISSUE;
  assign done       = state == FINISH;
  assign error      = state == ERR;
  assign busy       = state inside {ISSUE, WAIT, NEXT, FINISH};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      num          <= '0;
      timer        <= '0;
      batch_addr   <= '0;
      batch_idx    <= '0;
      batches_done <= '0;
    end else if (abort && state != IDLE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, ERR: if (cfg_start) begin
          num          <= cfg_num_batches;
          batch_addr   <= cfg_base_addr;
          batch_idx    <= '0;
          batches_done <= '0;
          timer        <= '0;
          state        <= cfg_num_batches != '0 ? ISSUE : FINISH;
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // a done arriving in the final timeout cycle still counts as success
          if (simd_done) state <= NEXT;
          else if (timer == TW'(TIMEOUT - 1)) state <= ERR;
          else timer <= timer + 1'b1;
        end
        NEXT: begin
          batches_done <= batches_done + 1'b1;
          if (batch_idx == num - CNT_W'(1)) state <= FINISH;
          else begin
            batch_idx  <= batch_idx + 1'b1;
            batch_addr <= batch_addr + ADDR_W'(LANES);
            state      <= ISSUE;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_simd_batch_scheduler.sv
// tb_simd_batch_scheduler: directed self-checking bench for simd_batch_scheduler
module tb_simd_batch_scheduler;
  logic        clk = 0;
  logic        rst = 1;
  logic        cfg_start = 0;
  logic [15:0] cfg_base_addr = '0;
  logic [7:0]  cfg_num_batches = '0;
  logic        abort = 0;
  logic        simd_start;
  logic        simd_done = 0;
  logic [15:0] batch_addr;
  logic [7:0]  batch_idx;
  logic [7:0]  batches_done;
  logic        busy;
  logic        done;
  logic        error;
  int n_chk = 0;
  int n_fail = 0;
  int n_start = 0;
  int n_done = 0;
  int s_start, s_done;

  simd_batch_scheduler #(.ADDR_W(16), .LANES(4), .CNT_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_num_batches(cfg_num_batches), .abort(abort), .simd_start(simd_start),
    .simd_done(simd_done), .batch_addr(batch_addr), .batch_idx(batch_idx),
    .batches_done(batches_done), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (simd_start) n_start++;
    if (done) n_done++;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(logic [15:0] base, logic [7:0] num);
    cfg_base_addr = base;
    cfg_num_batches = num;
    cfg_start = 1;
    step();
    cfg_start = 0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!simd_start && n < 40) begin
      step();
      n++;
    end
    chk("simd_start_seen", simd_start, 1);
  endtask

  task automatic serve(logic [15:0] exp_addr, logic [7:0] exp_idx, int delay);
    wait_start();
    chk("batch_addr", batch_addr, exp_addr);
    chk("batch_idx", batch_idx, exp_idx);
    chk("busy_issue", busy, 1);
    step();
    chk("simd_start_single", simd_start, 0);
    repeat (delay - 1) step();
    simd_done = 1;
    step();
    simd_done = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    chk("rst_busy", busy, 0);
    chk("rst_simd_start", simd_start, 0);
    chk("rst_addr", batch_addr, 0);
    chk("rst_error", error, 0);
    rst = 0;
    step();
    chk("idle_done", done, 0);

    // 1: three batches from 0x0100, done five cycles after each start
    s_start = n_start; s_done = n_done;
    start_run(16'h0100, 8'd3);
    serve(16'h0100, 8'd0, 5);
    serve(16'h0104, 8'd1, 5);
    serve(16'h0108, 8'd2, 5);
    step();
    chk("t1_done", done, 1);
    chk("t1_batches_done", batches_done, 3);
    step();
    chk("t1_done_low", done, 0);
    chk("t1_busy_low", busy, 0);
    chk("t1_start_count", n_start - s_start, 3);
    chk("t1_done_count", n_done - s_done, 1);
    chk("t1_addr_hold", batch_addr, 16'h0108);

    // 2: zero batches goes straight to FINISH
    s_start = n_start;
    start_run(16'h0200, 8'd0);
    chk("t2_done", done, 1);
    chk("t2_busy", busy, 1);
    step();
    chk("t2_done_low", done, 0);
    chk("t2_batches_done", batches_done, 0);
    chk("t2_no_start", n_start - s_start, 0);

    // 3: timeout into ERR, done ignored there, restart clears error
    s_done = n_done;
    start_run(16'h0200, 8'd2);
    wait_start();
    repeat (16) step();
    chk("t3_last_wait_error", error, 0);
    chk("t3_last_wait_busy", busy, 1);
    step();
    chk("t3_error", error, 1);
    chk("t3_busy", busy, 0);
    simd_done = 1;
    step();
    simd_done = 0;
    chk("t3_err_holds", error, 1);
    chk("t3_err_batches", batches_done, 0);
    chk("t3_no_done", n_done - s_done, 0);
    start_run(16'h0300, 8'd1);
    chk("t3_err_cleared", error, 0);
    chk("t3_restart_start", simd_start, 1);
    chk("t3_restart_addr", batch_addr, 16'h0300);
    // done arriving in the last allowed WAIT cycle wins over the timeout
    repeat (16) step();
    simd_done = 1;
    step();
    simd_done = 0;
    chk("t3_edge_no_error", error, 0);
    chk("t3_edge_busy", busy, 1);
    step();
    chk("t3_edge_done", done, 1);
    chk("t3_edge_batches", batches_done, 1);
    step();

    // 4: address wraps past 0xFFFF
    s_done = n_done;
    start_run(16'hFFFC, 8'd2);
    serve(16'hFFFC, 8'd0, 1);
    serve(16'h0000, 8'd1, 1);
    step();
    chk("t4_done", done, 1);
    chk("t4_batches", batches_done, 2);
    step();
    chk("t4_done_count", n_done - s_done, 1);

    // 5: cfg_start while busy is ignored; abort beats simd_done
    s_done = n_done;
    start_run(16'h0400, 8'd4);
    wait_start();
    chk("t5_addr0", batch_addr, 16'h0400);
    step();
    cfg_base_addr = 16'h0999;
    cfg_num_batches = 8'd7;
    cfg_start = 1;
    step();
    cfg_start = 0;
    repeat (2) step();
    simd_done = 1;
    step();
    simd_done = 0;
    wait_start();
    chk("t5_addr1", batch_addr, 16'h0404);
    chk("t5_idx1", batch_idx, 1);
    step();
    simd_done = 1;
    abort = 1;
    step();
    simd_done = 0;
    abort = 0;
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_done", done, 0);
    chk("t5_abort_batches", batches_done, 1);
    chk("t5_abort_idx", batch_idx, 1);
    repeat (3) step();
    chk("t5_no_done", n_done - s_done, 0);
    chk("t5_stays_idle", busy, 0);

    // 6: async reset mid-WAIT clears outputs without a clock edge
    start_run(16'h0500, 8'd2);
    wait_start();
    step();
    #2 rst = 1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_addr", batch_addr, 0);
    chk("t6_idx", batch_idx, 0);
    chk("t6_error", error, 0);
    step();
    rst = 0;
    step();
    start_run(16'h0600, 8'd1);
    serve(16'h0600, 8'd0, 1);
    step();
    chk("t6_done", done, 1);
    chk("t6_batches", batches_done, 1);
    step();
    chk("t6_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
